// File: rtl/spi_controller.sv
// SPI mode-0 controller: shifts one 16-bit {rw, addr, wdata} frame MSB-first
// on SCLK/COPI/nCS, with SCLK derived from clk by a programmable divider.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;
  localparam logic [PHASE_W-1:0] HALF_LOAD = PHASE_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] GAP_LOAD  = PHASE_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_t;

  state_t               state;
  logic [FRAME_W-1:0]   shreg;
  logic [BIT_W-1:0]     bit_cnt;
  logic [PHASE_W-1:0]   phase;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
      nCS     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {rw, addr, wdata};
            bit_cnt <= BIT_W'(FRAME_W - 1);
            phase   <= HALF_LOAD;
            busy    <= 1'b1;
            nCS     <= 1'b0;
            COPI    <= rw;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (phase == '0) begin
            phase <= HALF_LOAD;
            SCLK  <= 1'b1;
            state <= SHIFT_HI;
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end
        SHIFT_HI: begin
          if (phase == '0) begin
            phase <= HALF_LOAD;
            SCLK  <= 1'b0;
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
            // After bit 0 has been sampled there is nothing left to present.
            COPI  <= (bit_cnt == '0) ? 1'b0 : shreg[FRAME_W-2];
            state <= SHIFT_LO;
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end
        SHIFT_LO: begin
          if (phase == '0) begin
            if (bit_cnt == '0) begin
              phase <= GAP_LOAD;
              nCS   <= 1'b1;
              COPI  <= 1'b0;
              state <= GAP;
            end else begin
              phase   <= HALF_LOAD;
              bit_cnt <= bit_cnt - BIT_W'(1);
              SCLK    <= 1'b1;
              state   <= SHIFT_HI;
            end
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end
        GAP: begin
          if (phase == '0) begin
            phase <= HALF_LOAD;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          SCLK  <= 1'b0;
          COPI  <= 1'b0;
          nCS   <= 1'b1;
        end
      endcase
    end
  end

endmodule
